dma_transfer_engine: RTL and testbench

- Block-transfer DMA engine that moves 32-bit words between the system bus and port B of the 512-word dual-port DMA scratch memory.
- Port A of that memory stays owned by the CPU custom-instruction path.
- The CPU configures and polls the engine through its own custom instruction.
- Transfers are split into bus bursts; the engine is a bus master on the shared system bus.

---
 rtl/dma_transfer_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_dma_transfer_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_transfer_engine.sv
// Block-transfer DMA engine: moves 32-bit words between the system bus and port B of the
// 512-word scratch memory, configured and polled through a single custom instruction.
module dma_transfer_engine #(
  parameter logic [7:0]  customId = 8'h01,
  parameter int unsigned maxBurst = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result,
  output logic [8:0]  memAddressB,
  output logic        memWriteEnableB,
  output logic [31:0] memDataInB,
  input  logic [31:0] memDataOutB,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        beginTransaction,
  output logic [31:0] addressData,
  input  logic [31:0] addressDataIn,
  output logic [7:0]  burstSize,
  output logic        readNotWrite,
  output logic        dataValidOut,
  input  logic        dataValidIn,
  input  logic        busyIn,
  output logic        endTransactionOut,
  input  logic        endTransactionIn,
  input  logic        busErrorIn
);

  typedef enum logic [2:0] {
    StIdle, StReq, StBegin, StRd, StWrPrefetch, StWr, StEnd, StErr
  } state_e;

  localparam logic [7:0]  BurstMax   = 8'(maxBurst - 1);
  localparam logic [31:0] BurstMax32 = 32'(maxBurst - 1);

  state_e      state_q, state_d;
  logic [31:0] bus_start_q;
  logic [8:0]  mem_start_q;
  logic [9:0]  block_size_q;
  logic [7:0]  burst_len_q;
  logic        error_q, dir_rd_q;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        wr_last_q, wr_last_d;

  logic        ci_active, busy, cfg_we, ctrl_ok;
  logic [2:0]  sel;
  logic [9:0]  rem_m1;
  logic [7:0]  burst_sel;
  logic        unused_value_a;

  assign unused_value_a = ^{valueA[31:13], valueA[8:0]};

  assign ci_active = start && (ciN == customId);
  assign sel       = valueA[12:10];
  assign busy      = (state_q != StIdle);
  assign cfg_we    = ci_active && valueA[9] && !busy;
  assign ctrl_ok   = cfg_we && (sel == 3'd5) && (block_size_q != 10'd0) &&
                     ((valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10));

  assign rem_m1    = remaining_q - 10'd1;
  assign burst_sel = ({2'b00, burst_len_q} < rem_m1) ? burst_len_q : rem_m1[7:0];

  assign done = ci_active;

  always_comb begin
    result = '0;
    if (ci_active) begin
      case (sel)
        3'd1:    result = bus_start_q;
        3'd2:    result = {23'd0, mem_start_q};
        3'd3:    result = {22'd0, block_size_q};
        3'd4:    result = {24'd0, burst_len_q};
        3'd5:    result = {30'd0, error_q, busy};
        default: result = '0;
      endcase
    end
  end

  // Configuration and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_start_q  <= '0;
      mem_start_q  <= '0;
      block_size_q <= '0;
      burst_len_q  <= '0;
      error_q      <= 1'b0;
      dir_rd_q     <= 1'b0;
    end else begin
      if (state_q == StErr) begin
        error_q <= 1'b1;
      end else if (ctrl_ok) begin
        error_q  <= 1'b0;
        dir_rd_q <= valueB[0];
      end
      if (cfg_we) begin
        case (sel)
          3'd1: bus_start_q  <= {valueB[31:2], 2'b00};
          3'd2: mem_start_q  <= valueB[8:0];
          3'd3: block_size_q <= (valueB > 32'd512) ? 10'd512 : valueB[9:0];
          3'd4: burst_len_q  <= (valueB > BurstMax32) ? BurstMax : valueB[7:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      bus_addr_q  <= '0;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      burst_cnt_q <= '0;
      wr_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      burst_cnt_q <= burst_cnt_d;
      wr_last_q   <= wr_last_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus_addr_d        = bus_addr_q;
    mem_addr_d        = mem_addr_q;
    remaining_d       = remaining_q;
    burst_cnt_d       = burst_cnt_q;
    wr_last_d         = wr_last_q;
    memAddressB       = '0;
    memWriteEnableB   = 1'b0;
    memDataInB        = '0;
    busRequest        = 1'b0;
    beginTransaction  = 1'b0;
    addressData       = '0;
    burstSize         = '0;
    readNotWrite      = 1'b0;
    dataValidOut      = 1'b0;
    endTransactionOut = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_ok) begin
          state_d     = StReq;
          bus_addr_d  = bus_start_q;
          mem_addr_d  = mem_start_q;
          remaining_d = block_size_q;
        end
      end
      StReq: begin
        busRequest = 1'b1;
        if (busGrant) state_d = StBegin;
      end
      StBegin: begin
        busRequest       = 1'b1;
        beginTransaction = 1'b1;
        addressData      = bus_addr_q;
        burstSize        = burst_sel;
        readNotWrite     = dir_rd_q;
        burst_cnt_d      = burst_sel;
        wr_last_d        = 1'b0;
        state_d          = dir_rd_q ? StRd : StWrPrefetch;
      end
      StRd: begin
        busRequest  = 1'b1;
        memAddressB = mem_addr_q;
        memDataInB  = addressDataIn;
        if (dataValidIn) begin
          memWriteEnableB = 1'b1;
          mem_addr_d      = mem_addr_q + 9'd1;
          bus_addr_d      = bus_addr_q + 32'd4;
          if (remaining_q != 10'd0) remaining_d = remaining_q - 10'd1;
        end
        if (endTransactionIn) state_d = StEnd;
      end
      StWrPrefetch: begin
        busRequest  = 1'b1;
        memAddressB = mem_addr_q;
        state_d     = StWr;
      end
      StWr: begin
        busRequest  = 1'b1;
        memAddressB = mem_addr_q;
        if (wr_last_q) begin
          endTransactionOut = 1'b1;
          state_d           = StEnd;
        end else begin
          dataValidOut = 1'b1;
          addressData  = memDataOutB;
          if (!busyIn) begin
            // Present the next address now so its word is ready on the following cycle.
            memAddressB = mem_addr_q + 9'd1;
            mem_addr_d  = mem_addr_q + 9'd1;
            bus_addr_d  = bus_addr_q + 32'd4;
            if (remaining_q != 10'd0) remaining_d = remaining_q - 10'd1;
            if (burst_cnt_q == 8'd0) wr_last_d = 1'b1;
            else                     burst_cnt_d = burst_cnt_q - 8'd1;
          end
        end
      end
      StEnd: begin
        state_d = (remaining_q == 10'd0) ? StIdle : StReq;
      end
      StErr: begin
        state_d = StIdle;
      end
    endcase

    if (busErrorIn && (state_q != StIdle) && (state_q != StErr)) state_d = StErr;
  end

endmodule

// File: tb/tb_dma_transfer_engine.sv
// Scoreboard bench for dma_transfer_engine: stimulus pushes expected CI results, bus bursts,
// memory writes and bus write words; a negedge monitor pops and compares them.
module tb_dma_transfer_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] valueA, valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;
  logic [8:0]  memAddressB;
  logic        memWriteEnableB;
  logic [31:0] memDataInB, memDataOutB;
  logic        busRequest, busGrant, beginTransaction;
  logic [31:0] addressData, addressDataIn;
  logic [7:0]  burstSize;
  logic        readNotWrite, dataValidOut, dataValidIn, busyIn;
  logic        endTransactionOut, endTransactionIn, busErrorIn;

  always #5 clock = ~clock;

  dma_transfer_engine dut (
    .clock(clock), .reset(reset), .start(start), .valueA(valueA), .valueB(valueB), .ciN(ciN),
    .done(done), .result(result), .memAddressB(memAddressB), .memWriteEnableB(memWriteEnableB),
    .memDataInB(memDataInB), .memDataOutB(memDataOutB), .busRequest(busRequest),
    .busGrant(busGrant), .beginTransaction(beginTransaction), .addressData(addressData),
    .addressDataIn(addressDataIn), .burstSize(burstSize), .readNotWrite(readNotWrite),
    .dataValidOut(dataValidOut), .dataValidIn(dataValidIn), .busyIn(busyIn),
    .endTransactionOut(endTransactionOut), .endTransactionIn(endTransactionIn),
    .busErrorIn(busErrorIn)
  );

  // Scratch memory port B model with registered read, plus a preload path.
  logic [31:0] mem [512];
  logic [31:0] mem_rd;
  logic        pre_we;
  logic [8:0]  pre_addr;
  logic [31:0] pre_data;
  always @(posedge clock) begin
    if (pre_we)               mem[pre_addr] <= pre_data;
    else if (memWriteEnableB) mem[memAddressB] <= memDataInB;
    mem_rd <= mem[memAddressB];
  end
  assign memDataOutB = mem_rd;

  logic [32:0] ci_q[$];    // {check_result, value}
  logic [40:0] beg_q[$];   // {address, burstSize, readNotWrite}
  logic [40:0] memw_q[$];  // {mem address, data}
  logic [31:0] busw_q[$];
  int errors = 0;
  int checks = 0;
  int end_pulses = 0;

  // Slave controls
  int n_begin, err_burst, err_word, stall_word, stall_rem, wr_acc;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event %0h, expected none", name, act);
  endtask

  // Monitor
  logic [32:0] e_ci;
  logic [40:0] e_w;
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (ci_q.size() == 0) unexpected("ci_done", 64'(result));
        else begin
          e_ci = ci_q.pop_front();
          if (e_ci[32]) check("ci_result", 64'(result), 64'(e_ci[31:0]));
        end
      end
      if (beginTransaction) begin
        if (beg_q.size() == 0) unexpected("begin", 64'(addressData));
        else check("begin", 64'({addressData, burstSize, readNotWrite}), 64'(beg_q.pop_front()));
      end
      if (memWriteEnableB) begin
        if (memw_q.size() == 0) unexpected("mem_write", 64'({memAddressB, memDataInB}));
        else check("mem_write", 64'({memAddressB, memDataInB}), 64'(memw_q.pop_front()));
      end
      if (dataValidOut && !busyIn) begin
        if (busw_q.size() == 0) unexpected("bus_word", 64'(addressData));
        else begin
          e_w = 41'(busw_q.pop_front());
          check("bus_word", 64'(addressData), 64'(e_w));
        end
      end
      if (endTransactionOut) end_pulses++;
    end
  end

  // Bus slave: grants requests, returns read bursts, injects stalls and errors.
  int rd_left, rd_idx;
  logic rd_active;
  logic [31:0] rd_addr;
  initial begin
    busGrant = 0; dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; busyIn = 0;
    addressDataIn = 0; rd_active = 0; rd_left = 0; rd_idx = 0; rd_addr = 0;
    forever begin
      @(posedge clock); #1;
      dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; busyIn = 0;
      busGrant = busRequest;
      if (!busRequest) rd_active = 0;
      if (beginTransaction) begin
        n_begin++;
        if (readNotWrite) begin
          rd_active = 1; rd_left = int'(burstSize) + 1; rd_addr = addressData; rd_idx = 0;
        end
      end else if (rd_active) begin
        if (n_begin == err_burst && rd_idx == err_word) begin
          busErrorIn = 1; rd_active = 0;
        end else begin
          dataValidIn = 1; addressDataIn = pat(rd_addr);
          rd_addr += 4; rd_idx++; rd_left--;
          if (rd_left == 0) begin endTransactionIn = 1; rd_active = 0; end
        end
      end
      if (dataValidOut) begin
        if (wr_acc == stall_word && stall_rem > 0) begin busyIn = 1; stall_rem--; end
        else wr_acc++;
      end
    end
  end

  task automatic ci_write(input logic [2:0] s, input logic [31:0] d);
    start = 1; ciN = 8'h01; valueA = {19'd0, s, 1'b1, 9'd0}; valueB = d;
    ci_q.push_back({1'b0, 32'd0});
    @(posedge clock); #1;
    start = 0; valueA = 0; valueB = 0;
  endtask

  task automatic ci_read(input logic [2:0] s, input logic [31:0] exp);
    start = 1; ciN = 8'h01; valueA = {19'd0, s, 1'b0, 9'd0}; valueB = 0;
    ci_q.push_back({1'b1, exp});
    @(posedge clock); #1;
    start = 0; valueA = 0;
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return memw_q.size();
      1:       return busw_q.size();
      default: return beg_q.size();
    endcase
  endfunction

  task automatic wait_drain(input string name, input int which);
    int n = 0;
    while (qsize(which) != 0 && n < 2000) begin @(posedge clock); #1; n++; end
    if (qsize(which) != 0) begin
      checks++; errors++;
      $display("FAIL %s: timeout with %0d pending, expected 0", name, qsize(which));
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_bus_outs"}, 64'({busRequest, beginTransaction, readNotWrite, dataValidOut,
                                   endTransactionOut, burstSize, addressData}), 64'd0);
    check({tag, "_mem_outs"}, 64'({memWriteEnableB, memAddressB, memDataInB}), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1; start = 0; valueA = 0; valueB = 0; ciN = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    n_begin = 0; err_burst = 0; err_word = 0; stall_word = -1; stall_rem = 0; wr_acc = 0;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check_outs_zero("reset");
    check("reset_ci", 64'({done, result}), 64'd0);
    @(posedge clock); #1;
    ci_read(3'd5, 32'd0);

    // Config readback with clamping; foreign CI number must not respond.
    ci_write(3'd1, 32'h0000_1003);
    ci_write(3'd2, 32'h0000_03FF);
    ci_write(3'd3, 32'd600);
    ci_write(3'd4, 32'd40);
    ci_read(3'd1, 32'h0000_1000);
    ci_read(3'd2, 32'h0000_01FF);
    ci_read(3'd3, 32'd512);
    ci_read(3'd4, 32'd15);
    ci_read(3'd6, 32'd0);
    start = 1; ciN = 8'h02; valueA = {19'd0, 3'd1, 1'b0, 9'd0};
    @(negedge clock);
    check("foreign_ci", 64'({done, result}), 64'd0);
    @(posedge clock); #1;
    start = 0; ciN = 0; valueA = 0;

    // Start with blockSize 0 is ignored.
    ci_write(3'd3, 32'd0);
    ci_write(3'd5, 32'd1);
    ci_read(3'd5, 32'd0);

    // Bus read with memory wrap: bursts 8/8/4.
    ci_write(3'd1, 32'h0000_0100);
    ci_write(3'd2, 32'h0000_01F0);
    ci_write(3'd3, 32'd20);
    ci_write(3'd4, 32'd7);
    ci_write(3'd5, 32'd3);
    ci_read(3'd5, 32'd0);
    beg_q.push_back({32'h0000_0100, 8'd7, 1'b1});
    beg_q.push_back({32'h0000_0120, 8'd7, 1'b1});
    beg_q.push_back({32'h0000_0140, 8'd3, 1'b1});
    for (int i = 0; i < 20; i++)
      memw_q.push_back({9'(9'h1F0 + 9'(i)), pat(32'h100 + 32'(4 * i))});
    ci_write(3'd5, 32'd1);
    ci_read(3'd5, 32'd1);
    ci_write(3'd1, 32'h0000_5000);
    ci_write(3'd5, 32'd2);
    wait_drain("rd_words", 0);
    ci_read(3'd5, 32'd1);
    ci_read(3'd5, 32'd0);
    ci_read(3'd1, 32'h0000_0100);
    check("rd_begins_left", 64'(beg_q.size()), 64'd0);

    // Bus write with a 3-cycle stall on the second word.
    for (int i = 0; i < 4; i++) begin
      pre_we = 1; pre_addr = 9'(9'h040 + 9'(i)); pre_data = 32'(32'hA0 + 32'(i));
      @(posedge clock); #1;
    end
    pre_we = 0;
    ci_write(3'd1, 32'h0000_2000);
    ci_write(3'd2, 32'h0000_0040);
    ci_write(3'd3, 32'd4);
    ci_write(3'd4, 32'd15);
    beg_q.push_back({32'h0000_2000, 8'd3, 1'b0});
    for (int i = 0; i < 4; i++) busw_q.push_back(32'(32'hA0 + 32'(i)));
    wr_acc = 0; stall_word = 1; stall_rem = 3;
    ci_write(3'd5, 32'd2);
    wait_drain("wr_words", 1);
    repeat (3) begin @(posedge clock); #1; end
    check("wr_end_pulses", 64'(end_pulses), 64'd1);
    check("wr_stall_used", 64'(stall_rem), 64'd0);
    ci_read(3'd5, 32'd0);

    // Bus error in the second read burst.
    ci_write(3'd1, 32'h0000_0300);
    ci_write(3'd2, 32'h0000_0100);
    ci_write(3'd3, 32'd20);
    ci_write(3'd4, 32'd7);
    n_begin = 0; err_burst = 2; err_word = 2;
    beg_q.push_back({32'h0000_0300, 8'd7, 1'b1});
    beg_q.push_back({32'h0000_0320, 8'd7, 1'b1});
    for (int i = 0; i < 10; i++)
      memw_q.push_back({9'(9'h100 + 9'(i)), pat(32'h300 + 32'(4 * i))});
    ci_write(3'd5, 32'd1);
    n = 0;
    @(negedge clock);
    while (!busErrorIn && n < 1000) begin @(negedge clock); n++; end
    if (!busErrorIn) begin
      checks++; errors++;
      $display("FAIL err_wait: busErrorIn never driven, expected it within 1000 cycles");
    end
    @(negedge clock);
    check_outs_zero("err");
    @(posedge clock); #1;
    err_burst = 0;
    ci_read(3'd5, 32'd2);
    check("err_words_left", 64'(memw_q.size()), 64'd0);
    ci_write(3'd2, 32'h0000_0040);
    ci_write(3'd3, 32'd2);
    beg_q.push_back({32'h0000_0300, 8'd1, 1'b0});
    busw_q.push_back(32'hA0);
    busw_q.push_back(32'hA1);
    wr_acc = 0; stall_rem = 0;
    ci_write(3'd5, 32'd2);
    ci_read(3'd5, 32'd1);
    wait_drain("err_restart", 1);
    repeat (3) begin @(posedge clock); #1; end
    ci_read(3'd5, 32'd0);

    // Reset mid-burst.
    ci_write(3'd1, 32'h0000_0400);
    ci_write(3'd2, 32'h0000_0000);
    ci_write(3'd3, 32'd16);
    ci_write(3'd4, 32'd15);
    n_begin = 0;
    beg_q.push_back({32'h0000_0400, 8'd15, 1'b1});
    for (int i = 0; i < 3; i++) memw_q.push_back({9'(i), pat(32'h400 + 32'(4 * i))});
    ci_write(3'd5, 32'd1);
    wait_drain("pre_reset_words", 0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check_outs_zero("mid_reset");
    check("mid_reset_ci", 64'({done, result}), 64'd0);
    @(posedge clock); #1;
    ci_read(3'd5, 32'd0);
    ci_read(3'd1, 32'd0);
    ci_read(3'd2, 32'd0);
    ci_read(3'd3, 32'd0);
    ci_read(3'd4, 32'd0);
    repeat (3) begin @(posedge clock); #1; end

    check("ci_left", 64'(ci_q.size()), 64'd0);
    check("begin_left", 64'(beg_q.size()), 64'd0);
    check("memw_left", 64'(memw_q.size()), 64'd0);
    check("busw_left", 64'(busw_q.size()), 64'd0);
    check("total_end_pulses", 64'(end_pulses), 64'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
